// File: rtl/peri_pkg.sv
// peri_pkg: opcodes, widths and FSM states shared by the arbiter and the sum/counter peripheral
package peri_pkg;
  localparam int DATA_W = 32;
  localparam int OP_W = 3;
  localparam logic [OP_W-1:0] OP_CLR = 3'd0;
  localparam logic [OP_W-1:0] OP_ACC = 3'd1;
  localparam logic [OP_W-1:0] OP_RD_SUM = 3'd2;
  localparam logic [OP_W-1:0] OP_RD_CNT = 3'd3;
  localparam logic [OP_W-1:0] OP_RD_ZERO = 3'd4;
  localparam logic [OP_W-1:0] OP_NOP = 3'd7;
  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: two-way round-robin pick; on a tie the requester not granted last wins
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic valid,
  output logic idx
);
  assign valid = req0 | req1;
  assign idx = (req0 & req1) ? ~last_grant : req1;
endmodule

// File: rtl/peri_arbiter.sv
// peri_arbiter: shares one sum/counter peripheral between two requesters, one transaction per 3 cycles
module peri_arbiter #(
  parameter int DATA_W = peri_pkg::DATA_W,
  parameter int OP_W = peri_pkg::OP_W,
  parameter logic [OP_W-1:0] OP_NOP = peri_pkg::OP_NOP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [OP_W-1:0]   op0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              done0,
  output logic [DATA_W-1:0] rdata0,
  output logic              err0,
  input  logic              req1,
  input  logic [OP_W-1:0]   op1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              done1,
  output logic [DATA_W-1:0] rdata1,
  output logic              err1,
  output logic [OP_W-1:0]   peri_opcode,
  output logic [DATA_W-1:0] peri_wdata,
  input  logic [DATA_W-1:0] peri_rdata,
  output logic              busy
);
  import peri_pkg::*;
  state_t state;
  logic last_grant;
  logic win;
  logic pick_valid;
  logic pick_idx;
  logic illegal;
  logic rd_op;
  logic [OP_W-1:0] op_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rd_val;
  rr_pick2 u_pick (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .idx        (pick_idx)
  );
  // reset overrides the opcode so nothing reaches the peripheral in a reset cycle
  always_comb begin
    illegal = op_q > OP_W'(OP_RD_ZERO);
    rd_op = (op_q >= OP_W'(OP_RD_SUM)) && !illegal;
    rd_val = rd_op ? peri_rdata : '0;
    peri_opcode = (rst || state != ISSUE || illegal) ? OP_NOP : op_q;
    peri_wdata = (state == ISSUE) ? wdata_q : '0;
    busy = state != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last_grant <= 1'b1;
      win <= 1'b0;
      op_q <= OP_NOP;
      wdata_q <= '0;
      {gnt0, gnt1, done0, done1, err0, err1} <= '0;
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      {gnt0, gnt1, done0, done1, err0, err1} <= '0;
      case (state)
        IDLE: if (pick_valid) begin
          state <= ISSUE;
          win <= pick_idx;
          last_grant <= pick_idx;
          op_q <= pick_idx ? op1 : op0;
          wdata_q <= pick_idx ? wdata1 : wdata0;
          gnt0 <= !pick_idx;
          gnt1 <= pick_idx;
        end
        ISSUE: begin
          state <= DONE;
          done0 <= !win;
          done1 <= win;
          err0 <= !win && illegal;
          err1 <= win && illegal;
          if (win) rdata1 <= rd_val;
          else rdata0 <= rd_val;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_peri_arbiter.sv
// tb_peri_arbiter: directed, table-driven and randomized checks of peri_arbiter with a behavioural sum/counter peripheral
module tb_peri_arbiter;
  localparam int NR = 400;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0 = 1'b0, req1 = 1'b0;
  logic [2:0] op0 = 3'd0, op1 = 3'd0;
  logic [31:0] wdata0 = 32'd0, wdata1 = 32'd0;
  logic gnt0, gnt1, done0, done1, err0, err1, busy;
  logic [31:0] rdata0, rdata1, peri_wdata, peri_rdata;
  logic [2:0] peri_opcode;
  logic [31:0] psum = 32'd0, pcnt = 32'd0;
  int ntot = 0, npass = 0;

  peri_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .op0(op0), .wdata0(wdata0), .gnt0(gnt0), .done0(done0), .rdata0(rdata0), .err0(err0),
    .req1(req1), .op1(op1), .wdata1(wdata1), .gnt1(gnt1), .done1(done1), .rdata1(rdata1), .err1(err1),
    .peri_opcode(peri_opcode), .peri_wdata(peri_wdata), .peri_rdata(peri_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // shared peripheral: not reset by rst, only by a clear opcode
  always @(posedge clk) begin
    if (peri_opcode == 3'd0) begin
      psum <= 32'd0;
      pcnt <= 32'd0;
    end else if (peri_opcode == 3'd1) begin
      psum <= psum + peri_wdata;
      pcnt <= pcnt + 32'd1;
    end
  end
  assign peri_rdata = (peri_opcode == 3'd2) ? psum : (peri_opcode == 3'd3) ? pcnt : 32'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic txn(input bit r, input logic [2:0] op, input logic [31:0] wd, input logic [31:0] erd, input bit eerr);
    if (r) begin req1 = 1'b1; op1 = op; wdata1 = wd; end
    else begin req0 = 1'b1; op0 = op; wdata0 = wd; end
    @(negedge clk);
    chk("txn_idle_busy", 32'(busy), 32'd0);
    cyc;
    req0 = 1'b0; req1 = 1'b0;
    op0 = 3'($urandom); op1 = 3'($urandom); wdata0 = $urandom; wdata1 = $urandom;
    @(negedge clk);
    chk("txn_gnt", 32'({gnt1, gnt0, done1, done0}), r ? 32'b1000 : 32'b0100);
    chk("txn_issue_op", 32'(peri_opcode), eerr ? 32'd7 : 32'(op));
    chk("txn_issue_wd", peri_wdata, wd);
    cyc;
    @(negedge clk);
    chk("txn_done_err", 32'({gnt1, gnt0, done1, done0, err1, err0}), 32'({2'b00, r, !r, r & eerr, !r & eerr}));
    chk("txn_rdata", r ? rdata1 : rdata0, erd);
    chk("txn_done_op", 32'(peri_opcode), 32'd7);
    cyc;
  endtask

  typedef struct {
    logic rst, r0, r1;
    logic [1:0] g, d;
    logic b;
    logic [2:0] op;
    logic [31:0] wd;
  } vec_t;
  vec_t vt[26];

  logic [1:0] tg[NR+3], td[NR+3], te[NR+3];
  logic [2:0] top[NR+3];
  logic [31:0] twd[NR+3];
  logic [31:0] trd[2][NR+3];
  bit tset[2][NR+3];

  function automatic logic [2:0] rop();
    int r;
    r = $urandom_range(0, 9);
    return (r > 7) ? 3'd1 : 3'(r);
  endfunction

  initial begin
    logic [31:0] ps, msum, mcnt, res, wd;
    logic [31:0] crd[2];
    logic [2:0] op;
    int ndone, free_at, ph, w;
    bit lg;
    repeat (3) cyc;
    @(negedge clk);
    chk("reset_ctl", 32'({gnt1, gnt0, done1, done0, err1, err0, busy}), 32'd0);
    chk("reset_op", 32'(peri_opcode), 32'd7);
    chk("reset_rdata", rdata0 | rdata1, 32'd0);
    cyc;
    rst = 1'b0;
    txn(0, 3'd1, 32'd5, 32'd0, 0);
    txn(1, 3'd0, 32'd0, 32'd0, 0);
    txn(1, 3'd1, 32'd3, 32'd0, 0);
    txn(1, 3'd1, 32'd4, 32'd0, 0);
    txn(1, 3'd1, 32'd10, 32'd0, 0);
    txn(1, 3'd2, 32'd0, 32'd17, 0);
    txn(1, 3'd3, 32'd0, 32'd3, 0);
    txn(0, 3'd2, 32'd0, 32'd17, 0);
    txn(0, 3'd4, 32'd0, 32'd0, 0);
    txn(0, 3'd0, 32'd0, 32'd0, 0);
    txn(0, 3'd2, 32'd0, 32'd0, 0);
    chk("rdata1_held", rdata1, 32'd3);
    txn(0, 3'd1, 32'd7, 32'd0, 0);
    txn(0, 3'd2, 32'd0, 32'd7, 0);
    ps = psum;
    txn(0, 3'd6, 32'd99, 32'd0, 1);
    chk("illegal_sum_kept", psum, ps);
    // tie table: reset row, 8 alternating back-to-back transactions, one idle row
    vt[0] = '{rst: 1'b1, r0: 1'b0, r1: 1'b0, g: 2'b00, d: 2'b00, b: 1'b0, op: 3'd7, wd: 32'd0};
    for (int k = 0; k < 24; k++) begin
      ph = k % 3;
      w = (k / 3) % 2;
      vt[k+1] = '{rst: 1'b0, r0: 1'b1, r1: 1'b1,
                  g: (ph == 1) ? 2'(1 << w) : 2'b00, d: (ph == 2) ? 2'(1 << w) : 2'b00,
                  b: ph != 0, op: (ph == 1) ? 3'd1 : 3'd7,
                  wd: (ph == 1) ? (w == 1 ? 32'd2 : 32'd1) : 32'd0};
    end
    vt[25] = '{rst: 1'b0, r0: 1'b0, r1: 1'b0, g: 2'b00, d: 2'b00, b: 1'b0, op: 3'd7, wd: 32'd0};
    ndone = 0;
    foreach (vt[i]) begin
      rst = vt[i].rst; req0 = vt[i].r0; req1 = vt[i].r1;
      op0 = 3'd1; op1 = 3'd1; wdata0 = 32'd1; wdata1 = 32'd2;
      @(negedge clk);
      chk($sformatf("vec%0d_ctl", i), 32'({gnt1, gnt0, done1, done0, err1, err0, busy, peri_opcode}),
          32'({vt[i].g, vt[i].d, 2'b00, vt[i].b, vt[i].op}));
      chk($sformatf("vec%0d_wd", i), peri_wdata, vt[i].wd);
      ndone += int'(done0) + int'(done1);
      cyc;
    end
    chk("tie_completions", 32'(ndone), 32'd8);
    // reset during ISSUE aborts the transaction
    ps = psum;
    req0 = 1'b1; op0 = 3'd1; wdata0 = 32'd9;
    cyc;
    req0 = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("rst_issue_gnt", 32'(gnt0), 32'd1);
    chk("rst_issue_op", 32'(peri_opcode), 32'd7);
    cyc;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_after_ctl", 32'({gnt1, gnt0, done1, done0, err1, err0, busy}), 32'd0);
    chk("rst_sum_kept", psum, ps);
    req0 = 1'b1; req1 = 1'b1;
    cyc;
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    chk("rst_tie_winner", 32'({gnt1, gnt0}), 32'b01);
    cyc;
    cyc;
    // randomized run against a transaction-level timeline model
    rst = 1'b1;
    cyc;
    rst = 1'b0;
    for (int c = 0; c < NR + 3; c++) begin
      tg[c] = 2'b00; td[c] = 2'b00; te[c] = 2'b00; top[c] = 3'd7; twd[c] = 32'd0;
      for (int i = 0; i < 2; i++) begin tset[i][c] = 1'b0; trd[i][c] = 32'd0; end
    end
    msum = psum; mcnt = pcnt; free_at = 0; lg = 1'b1; crd[0] = 32'd0; crd[1] = 32'd0;
    for (int t = 0; t < NR; t++) begin
      req0 = $urandom_range(0, 9) < 6; req1 = $urandom_range(0, 9) < 6;
      op0 = rop(); op1 = rop();
      wdata0 = $urandom_range(0, 1000); wdata1 = $urandom_range(0, 1000);
      if (t >= free_at && (req0 || req1)) begin
        w = (req0 && req1) ? int'(!lg) : int'(req1);
        lg = w[0];
        free_at = t + 3;
        op = (w == 1) ? op1 : op0;
        wd = (w == 1) ? wdata1 : wdata0;
        res = (op == 3'd2) ? msum : (op == 3'd3) ? mcnt : 32'd0;
        if (op == 3'd0) begin msum = 32'd0; mcnt = 32'd0; end
        else if (op == 3'd1) begin msum += wd; mcnt += 32'd1; end
        tg[t+1][w] = 1'b1;
        top[t+1] = (op <= 3'd4) ? op : 3'd7;
        twd[t+1] = wd;
        td[t+2][w] = 1'b1;
        te[t+2][w] = op > 3'd4;
        tset[w][t+2] = 1'b1;
        trd[w][t+2] = res;
      end
      for (int i = 0; i < 2; i++) if (tset[i][t]) crd[i] = trd[i][t];
      @(negedge clk);
      chk($sformatf("rnd%0d_ctl", t), 32'({gnt1, gnt0, done1, done0, err1, err0, busy, peri_opcode}),
          32'({tg[t], td[t], te[t], (tg[t] != 2'b00 || td[t] != 2'b00), top[t]}));
      chk($sformatf("rnd%0d_wd", t), peri_wdata, twd[t]);
      chk($sformatf("rnd%0d_rd0", t), rdata0, crd[0]);
      chk($sformatf("rnd%0d_rd1", t), rdata1, crd[1]);
      cyc;
    end
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
